regfile_scoreboard: RTL and testbench

- Parametrised successor to the core's register file. Storage has a configurable width, depth and number of read ports.
- Adds optional writeback-to-read bypass and a per-register pending-write scoreboard.
- The scoreboard lets the pipelined decode stage detect RAW hazards on long-latency producers.
- Sits between decode (read/issue) and writeback; replaces the fixed 2-read/1-write 32x32 file.

---
 rtl/regfile_scoreboard_pkg.sv | 34 +++
 rtl/regfile_read_port.sv | 40 ++++
 rtl/regfile_scoreboard.sv | 125 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard_pkg
//  Description : Shared constants and bus helpers for the register file with
//                pending-write scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_scoreboard_pkg;

    // Default register width
    localparam int XLEN_DEFAULT = 32;

    // Index of the hard-wired zero register
    localparam int REG_X0 = 0;

    // Bounds of the generic slice helper
    localparam int BUS_MAX   = 256;
    localparam int SLICE_MAX = 64;

    // Return slice k (each w bits wide, w <= SLICE_MAX) of a flattened bus
    function automatic logic [SLICE_MAX-1:0] bus_slice(
        input logic [BUS_MAX-1:0] bus,
        input int                 k,
        input int                 w
    );
        logic [BUS_MAX-1:0]   shifted;
        logic [SLICE_MAX-1:0] mask;
        shifted = bus >> (k * w);
        mask    = (SLICE_MAX'(1) << w) - SLICE_MAX'(1);
        return SLICE_MAX'(shifted) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_read_port
//  Description : One combinational read port: zero-register, writeback bypass
//                and operand-ready selection.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_read_port
    import regfile_scoreboard_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] word,
    input  logic            pend,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data,
    output logic            ready
);

    // Priority: x0 constant, then same-cycle writeback, then storage/scoreboard
    always_comb begin
        data  = word;
        ready = ~pend;
        if ((ZERO_REG != 0) && (addr == AW'(REG_X0))) begin
            data  = '0;
            ready = 1'b1;
        end else if ((BYPASS != 0) && wb_en && (wb_addr == addr)) begin
            data  = wb_data;
            ready = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Parametrised register file with NUM_RD read ports, one
//                writeback port, optional bypass and a pending-write
//                scoreboard with a running pending count.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_ready,
    input  logic                   wb_en,
    input  logic [AW-1:0]          wb_addr,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr,
    input  logic                   flush,
    output logic [AW:0]            pend_cnt,
    output logic                   any_pend
);

    logic [XLEN-1:0]    r_regs [DEPTH];
    logic [DEPTH-1:0]   r_pend;
    logic [AW:0]        r_cnt;

    logic               w_wr;
    logic               w_set;
    logic               w_clr;
    logic               w_inc;
    logic               w_dec;
    logic [DEPTH-1:0]   w_pend_next;
    logic [AW:0]        w_cnt_next;
    logic [BUS_MAX-1:0] w_addr_bus;

    // x0 is immune to writes and issues when hard-wired to zero
    assign w_wr  = wb_en  && !((ZERO_REG != 0) && (wb_addr  == AW'(REG_X0)));
    assign w_set = iss_en && !((ZERO_REG != 0) && (iss_addr == AW'(REG_X0)));
    assign w_clr = wb_en;

    // Next pending vector and count delta; set applied after clear so a
    // same-address issue (the new producer) wins over the retiring one
    always_comb begin
        w_pend_next = r_pend;
        w_inc       = 1'b0;
        w_dec       = 1'b0;
        w_cnt_next  = r_cnt;
        if (flush) begin
            w_pend_next = '0;
            w_cnt_next  = '0;
        end else begin
            if (w_clr) begin
                w_pend_next[wb_addr] = 1'b0;
            end
            if (w_set) begin
                w_pend_next[iss_addr] = 1'b1;
            end
            w_inc      = w_set && !r_pend[iss_addr];
            w_dec      = w_clr && r_pend[wb_addr] && !(w_set && (iss_addr == wb_addr));
            w_cnt_next = r_cnt + (AW+1)'(w_inc) - (AW+1)'(w_dec);
        end
    end

    // Register storage; the writeback is honoured even during a flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Scoreboard bits and incrementally maintained popcount
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            r_pend <= w_pend_next;
            r_cnt  <= w_cnt_next;
        end
    end

    assign pend_cnt   = r_cnt;
    assign any_pend   = (r_cnt != '0);
    assign w_addr_bus = BUS_MAX'(rd_addr);

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [AW-1:0] w_addr;
            assign w_addr = AW'(bus_slice(w_addr_bus, k, AW));

            regfile_read_port #(
                .XLEN     (XLEN),
                .AW       (AW),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS)
            ) u_rd (
                .addr    (w_addr),
                .word    (r_regs[w_addr]),
                .pend    (r_pend[w_addr]),
                .wb_en   (wb_en),
                .wb_addr (wb_addr),
                .wb_data (wb_data),
                .data    (rd_data[k*XLEN +: XLEN]),
                .ready   (rd_ready[k])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_scoreboard
//  Description : Directed self-checking bench for regfile_scoreboard
//                (defaults: 32x32, two read ports, zero reg, bypass).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;
    logic [5:0]  pend_cnt;
    logic        any_pend;

    int n_vec;
    int n_err;

    regfile_scoreboard dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .pend_cnt (pend_cnt),
        .any_pend (any_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        rd_addr  = '0;
        wb_en    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
        #22;
        rst_n = 1'b1;

        // Reset state across all addresses
        chk("rst_cnt", 64'(pend_cnt), 64'd0);
        chk("rst_any", 64'(any_pend), 64'd0);
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(31 - a));
            chk("rst_data", rd_data, 64'd0);
            chk("rst_ready", 64'(rd_ready), 64'd3);
        end

        // Same-cycle bypass, then storage path
        tick();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        set_rd(5'd5, 5'd6);
        chk("byp_data0", 64'(rd_data[31:0]), 64'hDEADBEEF);
        chk("byp_data1", 64'(rd_data[63:32]), 64'd0);
        chk("byp_ready", 64'(rd_ready), 64'd3);
        tick();
        wb_en = 1'b0;
        #1;
        chk("stor_data5", 64'(rd_data[31:0]), 64'hDEADBEEF);

        // Write to x0 is ignored
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1;
        set_rd(5'd0, 5'd5);
        chk("x0_byp", 64'(rd_data[31:0]), 64'd0);
        tick();
        wb_en = 1'b0;
        #1;
        chk("x0_stor", rd_data, {32'hDEADBEEF, 32'h0});

        // Issue to 7, retire two cycles later with bypass
        iss_en = 1'b1; iss_addr = 5'd7;
        tick();
        iss_en = 1'b0;
        set_rd(5'd7, 5'd0);
        chk("iss7_ready", 64'(rd_ready), 64'd2);
        chk("iss7_cnt", 64'(pend_cnt), 64'd1);
        chk("iss7_any", 64'(any_pend), 64'd1);
        tick();
        chk("iss7_hold", 64'(rd_ready[0]), 64'd0);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h55;
        #1;
        chk("wb7_data", 64'(rd_data[31:0]), 64'h55);
        chk("wb7_ready", 64'(rd_ready[0]), 64'd1);
        tick();
        wb_en = 1'b0;
        #1;
        chk("wb7_cnt", 64'(pend_cnt), 64'd0);
        chk("wb7_stor", 64'(rd_data[31:0]), 64'h55);
        chk("wb7_rdy2", 64'(rd_ready[0]), 64'd1);

        // Issue and writeback to 9 together: new producer keeps it pending
        iss_en = 1'b1; iss_addr = 5'd9;
        wb_en  = 1'b1; wb_addr  = 5'd9; wb_data = 32'hA;
        tick();
        iss_en = 1'b0; wb_en = 1'b0;
        set_rd(5'd9, 5'd7);
        chk("r9_data", 64'(rd_data[31:0]), 64'hA);
        chk("r9_ready", 64'(rd_ready), 64'd2);
        chk("r9_cnt", 64'(pend_cnt), 64'd1);

        // Retire 9 (plain writeback), then issue to x0 which is ignored
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hB;
        tick();
        wb_en = 1'b0;
        iss_en = 1'b1; iss_addr = 5'd0;
        tick();
        iss_en = 1'b0;
        set_rd(5'd0, 5'd9);
        chk("x0iss_cnt", 64'(pend_cnt), 64'd0);
        chk("x0iss_rdy", 64'(rd_ready), 64'd3);
        chk("r9b_data", 64'(rd_data[63:32]), 64'hB);

        // Issue 3, 4, 6, then flush with a same-cycle issue and writeback
        iss_en = 1'b1;
        iss_addr = 5'd3; tick();
        iss_addr = 5'd4; tick();
        iss_addr = 5'd6; tick();
        iss_en = 1'b0;
        set_rd(5'd3, 5'd6);
        chk("three_cnt", 64'(pend_cnt), 64'd3);
        chk("three_rdy", 64'(rd_ready), 64'd0);
        flush = 1'b1;
        iss_en = 1'b1; iss_addr = 5'd8;
        wb_en  = 1'b1; wb_addr  = 5'd3; wb_data = 32'h77;
        tick();
        flush = 1'b0; iss_en = 1'b0; wb_en = 1'b0;
        set_rd(5'd3, 5'd8);
        chk("fl_cnt", 64'(pend_cnt), 64'd0);
        chk("fl_any", 64'(any_pend), 64'd0);
        chk("fl_data3", 64'(rd_data[31:0]), 64'h77);
        chk("fl_rdy", 64'(rd_ready), 64'd3);
        set_rd(5'd4, 5'd6);
        chk("fl_rdy46", 64'(rd_ready), 64'd3);

        // Writeback to a non-pending register leaves count at zero
        wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h1234;
        tick();
        wb_en = 1'b0;
        set_rd(5'd10, 5'd3);
        chk("np_cnt", 64'(pend_cnt), 64'd0);
        chk("np_data", rd_data, {32'h77, 32'h1234});

        // Double issue to 2 counts once; then 12
        iss_en = 1'b1; iss_addr = 5'd2;
        tick();
        tick();
        iss_addr = 5'd12;
        tick();
        iss_en = 1'b0;
        set_rd(5'd2, 5'd12);
        chk("p2_cnt", 64'(pend_cnt), 64'd2);
        chk("p2_rdy", 64'(rd_ready), 64'd0);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", 64'(pend_cnt), 64'd0);
        chk("arst_any", 64'(any_pend), 64'd0);
        chk("arst_rdy", 64'(rd_ready), 64'd3);
        set_rd(5'd5, 5'd3);
        chk("arst_d53", rd_data, 64'd0);
        set_rd(5'd7, 5'd10);
        chk("arst_d710", rd_data, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_cnt", 64'(pend_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
